// File: rtl/nios2_cpu_cpu_debug_ocimem_arbiter.sv
// Arbitrates the single-port OCI debug RAM between JTAG debug-slave commands
// and the Avalon debug memory slave, alternating grants when both request.
module nios2_cpu_cpu_debug_ocimem_arbiter #(
    parameter int RAM_AW = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    input  logic [37:0]       jdo,
    input  logic [RAM_AW-1:0] avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [31:0]       avs_writedata,
    input  logic [3:0]        avs_byteenable,
    output logic [31:0]       avs_readdata,
    output logic              avs_waitrequest,
    output logic [RAM_AW-1:0] ram_addr,
    output logic              ram_wr,
    output logic [31:0]       ram_wdata,
    output logic [3:0]        ram_be,
    input  logic [31:0]       ram_rdata,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error,
    output logic [1:0]        dbg_state,
    output logic              dbg_jreq_valid,
    output logic [RAM_AW-1:0] dbg_mon_areg
);

    if (RD_LAT != 1) begin : g_bad_rd_lat
        $error("RD_LAT must be 1");
    end
    if (RAM_AW < 4 || RAM_AW > 16) begin : g_bad_ram_aw
        $error("RAM_AW must be within 4..16");
    end

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_J_RD = 2'd1, S_A_RD = 2'd2} state_t;
    typedef enum logic {G_AVS = 1'b0, G_JTAG = 1'b1} grant_t;

    state_t            state_q, state_d;
    grant_t            last_grant_q, last_grant_d;
    logic [31:0]       mon_d_reg_q, mon_d_reg_d;
    logic [RAM_AW-1:0] mon_a_reg_q, mon_a_reg_d;
    logic              monitor_ready_q, monitor_ready_d;
    logic              monitor_error_q, monitor_error_d;
    logic              jreq_valid_q, jreq_valid_d;
    logic              jreq_wr_q, jreq_wr_d;
    logic [31:0]       jreq_wdata_q, jreq_wdata_d;

    logic avs_req, grant_j, grant_a, j_done, any_pulse;
    logic unused_jdo_bits;

    assign unused_jdo_bits = ^{jdo[2:0], jdo[35]};
    assign avs_req   = avs_read | avs_write;
    assign any_pulse = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;

    // Avalon handshake: the master holds avs_read/avs_write (level) until a cycle
    // with avs_waitrequest=0; the transfer happens in that cycle and only then.
    always_comb begin
        grant_j = 1'b0;
        grant_a = 1'b0;
        if (state_q == S_IDLE && !reset) begin
            grant_j = jreq_valid_q & (!avs_req | (last_grant_q == G_AVS));
            grant_a = !grant_j & avs_req;
        end
        j_done = (grant_j & jreq_wr_q) | (state_q == S_J_RD);
    end

    always_comb begin
        ram_addr        = mon_a_reg_q;
        ram_wr          = 1'b0;
        ram_wdata       = jreq_wdata_q;
        ram_be          = 4'hF;
        avs_waitrequest = 1'b1;
        avs_readdata    = '0;
        if (grant_a) begin
            ram_addr        = avs_address;
            ram_wdata       = avs_writedata;
            ram_be          = avs_byteenable;
            ram_wr          = avs_write;
            avs_waitrequest = !avs_write;
        end else if (grant_j) begin
            ram_wr = jreq_wr_q;
        end
        if (state_q == S_A_RD && !reset) begin
            avs_waitrequest = 1'b0;
            avs_readdata    = ram_rdata;
        end
    end

    always_comb begin
        state_d         = state_q;
        last_grant_d    = last_grant_q;
        mon_d_reg_d     = mon_d_reg_q;
        mon_a_reg_d     = mon_a_reg_q;
        monitor_ready_d = monitor_ready_q;
        monitor_error_d = monitor_error_q;
        jreq_valid_d    = jreq_valid_q;
        jreq_wr_d       = jreq_wr_q;
        jreq_wdata_d    = jreq_wdata_q;

        case (state_q)
            S_IDLE: begin
                if (grant_j && !jreq_wr_q)      state_d = S_J_RD;
                else if (grant_a && !avs_write) state_d = S_A_RD;
            end
            S_J_RD: begin
                mon_d_reg_d = ram_rdata;
                state_d     = S_IDLE;
            end
            S_A_RD:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (grant_j)      last_grant_d = G_JTAG;
        else if (grant_a) last_grant_d = G_AVS;

        if (j_done) begin
            mon_a_reg_d     = mon_a_reg_q + RAM_AW'(1);
            jreq_valid_d    = 1'b0;
            monitor_ready_d = 1'b1;
        end

        // Capture comes after completion so a command accepted in the
        // completing cycle overrides the completion's clear/set.
        if (any_pulse) begin
            if (jreq_valid_q && !j_done) begin
                monitor_error_d = 1'b1;
            end else if (take_action_ocimem_a) begin
                mon_a_reg_d = jdo[17 +: RAM_AW];
                if (jdo[37]) monitor_error_d = 1'b0;
                if (jdo[36]) begin
                    jreq_valid_d    = 1'b1;
                    jreq_wr_d       = 1'b0;
                    monitor_ready_d = 1'b0;
                end
            end else if (take_action_ocimem_b) begin
                jreq_valid_d    = 1'b1;
                jreq_wr_d       = 1'b1;
                jreq_wdata_d    = jdo[34:3];
                monitor_ready_d = 1'b0;
            end else begin
                jreq_valid_d    = 1'b1;
                jreq_wr_d       = 1'b0;
                monitor_ready_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= S_IDLE;
            last_grant_q    <= G_AVS;
            mon_d_reg_q     <= '0;
            mon_a_reg_q     <= '0;
            monitor_ready_q <= 1'b0;
            monitor_error_q <= 1'b0;
            jreq_valid_q    <= 1'b0;
            jreq_wr_q       <= 1'b0;
            jreq_wdata_q    <= '0;
        end else begin
            state_q         <= state_d;
            last_grant_q    <= last_grant_d;
            mon_d_reg_q     <= mon_d_reg_d;
            mon_a_reg_q     <= mon_a_reg_d;
            monitor_ready_q <= monitor_ready_d;
            monitor_error_q <= monitor_error_d;
            jreq_valid_q    <= jreq_valid_d;
            jreq_wr_q       <= jreq_wr_d;
            jreq_wdata_q    <= jreq_wdata_d;
        end
    end

    assign MonDReg        = mon_d_reg_q;
    assign monitor_ready  = monitor_ready_q;
    assign monitor_error  = monitor_error_q;
    assign dbg_state      = state_q;
    assign dbg_jreq_valid = jreq_valid_q;
    assign dbg_mon_areg   = mon_a_reg_q;

endmodule

// File: tb/tb_nios2_cpu_cpu_debug_ocimem_arbiter.sv
// Bench for the OCI memory arbiter: bench-owned RAM, transaction-level memory
// model for expected data, directed timing scenarios plus randomized traffic.
module tb_nios2_cpu_cpu_debug_ocimem_arbiter;

    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a;
    logic [37:0]   jdo;
    logic [AW-1:0] avs_address;
    logic          avs_read, avs_write;
    logic [31:0]   avs_writedata;
    logic [3:0]    avs_byteenable;
    logic [31:0]   avs_readdata;
    logic          avs_waitrequest;
    logic [AW-1:0] ram_addr;
    logic          ram_wr;
    logic [31:0]   ram_wdata;
    logic [3:0]    ram_be;
    logic [31:0]   ram_rdata;
    logic [31:0]   MonDReg;
    logic          monitor_ready, monitor_error;
    logic [1:0]    dbg_state;
    logic          dbg_jreq_valid;
    logic [AW-1:0] dbg_mon_areg;

    nios2_cpu_cpu_debug_ocimem_arbiter #(.RAM_AW(AW), .RD_LAT(1)) dut (
        .clk(clk), .reset(reset),
        .take_action_ocimem_a(take_action_ocimem_a),
        .take_action_ocimem_b(take_action_ocimem_b),
        .take_no_action_ocimem_a(take_no_action_ocimem_a),
        .jdo(jdo),
        .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
        .avs_writedata(avs_writedata), .avs_byteenable(avs_byteenable),
        .avs_readdata(avs_readdata), .avs_waitrequest(avs_waitrequest),
        .ram_addr(ram_addr), .ram_wr(ram_wr), .ram_wdata(ram_wdata), .ram_be(ram_be),
        .ram_rdata(ram_rdata),
        .MonDReg(MonDReg), .monitor_ready(monitor_ready), .monitor_error(monitor_error),
        .dbg_state(dbg_state), .dbg_jreq_valid(dbg_jreq_valid), .dbg_mon_areg(dbg_mon_areg)
    );

    always #5 clk = ~clk;

    // ---------------- bench RAM (1-cycle read latency) ----------------
    logic [31:0]   mem [0:255];
    logic          pre_we;
    logic [AW-1:0] pre_addr;
    logic [31:0]   pre_data;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (be[i]) r[i*8 +: 8] = d[i*8 +: 8];
        return r;
    endfunction

    always @(posedge clk) begin
        if (pre_we)      mem[pre_addr] <= pre_data;
        else if (ram_wr) mem[ram_addr] <= merge(mem[ram_addr], ram_wdata, ram_be);
        ram_rdata <= mem[ram_addr];
    end

    // ---------------- reference model ----------------
    logic [31:0]   ref_mem [0:255];
    logic [AW-1:0] ref_a;
    logic [31:0]   ref_dreg;
    logic          ref_err, ref_ready;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [37:0] jdo_load(input logic [7:0] a, input logic rd, input logic clr);
        logic [37:0] v;
        v = '0;
        v[24:17] = a;
        v[36] = rd;
        v[37] = clr;
        return v;
    endfunction

    function automatic logic [37:0] jdo_wr(input logic [31:0] d);
        logic [37:0] v;
        v = '0;
        v[34:3] = d;
        return v;
    endfunction

    task automatic check_model(input string tag);
        chk({tag, "_dreg"}, MonDReg, ref_dreg);
        chk({tag, "_areg"}, 32'(dbg_mon_areg), 32'(ref_a));
        chk({tag, "_err"}, 32'(monitor_error), 32'(ref_err));
        chk({tag, "_ready"}, 32'(monitor_ready), 32'(ref_ready));
    endtask

    // ---------------- drivers ----------------
    task automatic pulse(input int kind, input logic [37:0] v);
        jdo = v;
        take_action_ocimem_a    = (kind == 0);
        take_action_ocimem_b    = (kind == 1);
        take_no_action_ocimem_a = (kind == 2);
        @(posedge clk); #1;
        take_action_ocimem_a    = 1'b0;
        take_action_ocimem_b    = 1'b0;
        take_no_action_ocimem_a = 1'b0;
    endtask

    // kind: 0 = address load, 1 = write+inc, 2 = read+inc
    task automatic jtag_cmd(input int kind, input logic [37:0] v);
        logic queued, seen;
        logic [AW-1:0] wa;
        queued = (kind != 0) || v[36];
        @(posedge clk); #1;
        pulse(kind, v);
        if (kind == 0) begin
            ref_a = v[24:17];
            if (v[37]) ref_err = 1'b0;
        end
        wa = ref_a;
        if (queued) begin
            if (kind == 1) ref_mem[ref_a] = v[34:3];
            else           ref_dreg = ref_mem[ref_a];
            ref_a = ref_a + 8'd1;
            ref_ready = 1'b1;
            seen = 1'b0;
            for (int i = 0; i < 20 && !seen; i++) begin
                @(negedge clk);
                seen = monitor_ready;
            end
            chk("jtag_done", 32'(seen), 32'd1);
            if (kind == 1) chk("jtag_wr_mem", mem[wa], ref_mem[wa]);
        end else begin
            @(negedge clk);
        end
        check_model("jtag");
    endtask

    task automatic avs_op(input logic wr, input logic [7:0] a, input logic [31:0] d,
                          input logic [3:0] be);
        logic done;
        @(posedge clk); #1;
        avs_address = a; avs_read = !wr; avs_write = wr;
        avs_writedata = d; avs_byteenable = be;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (!avs_waitrequest) begin
                done = 1'b1;
                if (wr) begin
                    chk("avs_wr_strobe", 32'(ram_wr), 32'd1);
                    chk("avs_wr_addr", 32'(ram_addr), 32'(a));
                    chk("avs_wr_be", 32'(ram_be), 32'(be));
                    ref_mem[a] = merge(ref_mem[a], d, be);
                end else begin
                    chk("avs_rdata", avs_readdata, ref_mem[a]);
                end
            end
        end
        chk("avs_done", 32'(done), 32'd1);
        @(posedge clk); #1;
        avs_read = 1'b0; avs_write = 1'b0;
        if (wr) chk("avs_wr_mem", mem[a], ref_mem[a]);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog");
    end

    initial begin
        int jcnt, acnt, wr_lo, jrd;
        logic pend;
        logic seq[$];
        logic [AW-1:0] idx;
        logic [31:0] old;

        reset = 1'b1;
        take_action_ocimem_a = 1'b0; take_action_ocimem_b = 1'b0; take_no_action_ocimem_a = 1'b0;
        jdo = '0; avs_address = '0; avs_read = 1'b0; avs_write = 1'b0;
        avs_writedata = '0; avs_byteenable = '0;
        pre_we = 1'b0; pre_addr = '0; pre_data = '0;

        // ---- preload RAM while in reset ----
        for (int i = 0; i < 256; i++) begin
            @(posedge clk); #1;
            pre_we = 1'b1;
            pre_addr = 8'(i);
            pre_data = (i == 16) ? 32'hCAFEF00D : $urandom;
            ref_mem[i] = pre_data;
        end
        @(posedge clk); #1;
        pre_we = 1'b0;
        ref_a = '0; ref_dreg = '0; ref_err = 1'b0; ref_ready = 1'b0;

        // ---- reset state ----
        @(negedge clk);
        avs_write = 1'b1; avs_address = 8'h33;
        #1;
        chk("rst_waitreq", 32'(avs_waitrequest), 32'd1);
        chk("rst_ram_wr", 32'(ram_wr), 32'd0);
        chk("rst_readdata", avs_readdata, 32'd0);
        chk("rst_state", 32'(dbg_state), 32'd0);
        chk("rst_jreq", 32'(dbg_jreq_valid), 32'd0);
        check_model("rst");
        avs_write = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;

        // ---- load then read 0x10, exact latency ----
        @(posedge clk); #1;
        jdo = jdo_load(8'h10, 1'b1, 1'b0); take_action_ocimem_a = 1'b1;
        @(posedge clk); #1;
        take_action_ocimem_a = 1'b0;
        @(negedge clk);
        chk("ldrd_n1_addr", 32'(ram_addr), 32'h10);
        chk("ldrd_n1_ready", 32'(monitor_ready), 32'd0);
        @(negedge clk);
        chk("ldrd_n2_state", 32'(dbg_state), 32'd1);
        chk("ldrd_n2_ready", 32'(monitor_ready), 32'd0);
        @(negedge clk);
        ref_a = 8'h11; ref_dreg = ref_mem[8'h10]; ref_ready = 1'b1;
        chk("ldrd_n3_jreq", 32'(dbg_jreq_valid), 32'd0);
        check_model("ldrd_n3");

        // ---- write burst with address wrap ----
        jtag_cmd(0, jdo_load(8'hFF, 1'b0, 1'b0));
        @(posedge clk); #1;
        jdo = jdo_wr(32'h11111111); take_action_ocimem_b = 1'b1;
        @(posedge clk); #1;
        take_action_ocimem_b = 1'b0;
        @(negedge clk);
        chk("wb1_ram_wr", 32'(ram_wr), 32'd1);
        chk("wb1_addr", 32'(ram_addr), 32'hFF);
        chk("wb1_wdata", ram_wdata, 32'h11111111);
        chk("wb1_be", 32'(ram_be), 32'hF);
        @(negedge clk);
        chk("wb1_ready", 32'(monitor_ready), 32'd1);
        chk("wb1_ram_wr_off", 32'(ram_wr), 32'd0);
        @(posedge clk); #1;
        jdo = jdo_wr(32'h22222222); take_action_ocimem_b = 1'b1;
        @(posedge clk); #1;
        take_action_ocimem_b = 1'b0;
        @(negedge clk);
        chk("wb2_ram_wr", 32'(ram_wr), 32'd1);
        chk("wb2_addr", 32'(ram_addr), 32'h00);
        @(negedge clk);
        ref_mem[8'hFF] = 32'h11111111; ref_mem[8'h00] = 32'h22222222;
        ref_a = 8'h01; ref_ready = 1'b1;
        chk("wb_mem_ff", mem[8'hFF], 32'h11111111);
        chk("wb_mem_00", mem[8'h00], 32'h22222222);
        check_model("wb2");

        // ---- Avalon write with partial byte enables ----
        old = ref_mem[8'h20];
        @(posedge clk); #1;
        avs_address = 8'h20; avs_write = 1'b1; avs_writedata = 32'hAABBCCDD; avs_byteenable = 4'b0101;
        @(negedge clk);
        chk("aw_ram_wr", 32'(ram_wr), 32'd1);
        chk("aw_be", 32'(ram_be), 32'h5);
        chk("aw_wdata", ram_wdata, 32'hAABBCCDD);
        chk("aw_addr", 32'(ram_addr), 32'h20);
        chk("aw_waitreq", 32'(avs_waitrequest), 32'd0);
        @(posedge clk); #1;
        avs_write = 1'b0;
        @(negedge clk);
        ref_mem[8'h20] = {old[31:24], 8'hBB, old[15:8], 8'hDD};
        chk("aw_ram_wr_off", 32'(ram_wr), 32'd0);
        chk("aw_mem", mem[8'h20], ref_mem[8'h20]);

        // ---- contention: Avalon read held, 4 JTAG reads ----
        @(posedge clk); #1;
        avs_address = 8'h30; avs_read = 1'b1;
        jdo = jdo_load(8'h40, 1'b1, 1'b0); take_action_ocimem_a = 1'b1;
        @(posedge clk); #1;
        take_action_ocimem_a = 1'b0;
        jcnt = 0; acnt = 0; wr_lo = 0; pend = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            take_no_action_ocimem_a = 1'b0;
            if (pend) begin
                idx = 8'(8'h40 + jcnt - 1);
                chk("cont_mondreg", MonDReg, ref_mem[idx]);
                pend = 1'b0;
                if (jcnt == 4) break;
            end
            if (!avs_waitrequest) wr_lo++;
            if (dbg_state == 2'd2) begin
                chk("cont_avs_rdata", avs_readdata, ref_mem[8'h30]);
                acnt++;
                seq.push_back(1'b0);
            end else if (dbg_state == 2'd1) begin
                jcnt++;
                seq.push_back(1'b1);
                pend = 1'b1;
                if (jcnt < 4) take_no_action_ocimem_a = 1'b1;
            end
        end
        avs_read = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        chk("cont_jreads", 32'(jcnt), 32'd4);
        chk("cont_agrants", 32'(acnt), 32'd4);
        chk("cont_wr_lo", 32'(wr_lo), 32'(acnt));
        if (seq.size() > 0) chk("cont_first_avs", 32'(seq[0]), 32'd0);
        for (int i = 1; i < seq.size(); i++)
            chk("cont_alternate", 32'(seq[i] != seq[i-1]), 32'd1);
        ref_a = 8'h44; ref_dreg = ref_mem[8'h43]; ref_ready = 1'b1;
        check_model("cont");

        // ---- overflow while Avalon holds the RAM ----
        @(posedge clk); #1;
        avs_address = 8'h31; avs_read = 1'b1;
        jdo = jdo_load(8'h50, 1'b1, 1'b0); take_action_ocimem_a = 1'b1;
        @(posedge clk); #1;
        jdo = jdo_load(8'h60, 1'b1, 1'b1);
        @(posedge clk); #1;
        take_action_ocimem_a = 1'b0;
        @(negedge clk);
        chk("ovf_err_set", 32'(monitor_error), 32'd1);
        chk("ovf_no_load", 32'(dbg_mon_areg), 32'h50);
        chk("ovf_pending", 32'(dbg_jreq_valid), 32'd1);
        jrd = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (dbg_state == 2'd1) jrd++;
        end
        avs_read = 1'b0;
        chk("ovf_one_jread", 32'(jrd), 32'd1);
        chk("ovf_jreq_clear", 32'(dbg_jreq_valid), 32'd0);
        ref_a = 8'h51; ref_dreg = ref_mem[8'h50]; ref_err = 1'b1; ref_ready = 1'b1;
        check_model("ovf");
        jtag_cmd(0, jdo_load(8'h70, 1'b0, 1'b1));

        // ---- reset during J_RD ----
        @(posedge clk); #1;
        take_no_action_ocimem_a = 1'b1;
        @(posedge clk); #1;
        take_no_action_ocimem_a = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rjrd_state", 32'(dbg_state), 32'd1);
        reset = 1'b1; avs_write = 1'b1; avs_address = 8'h34;
        #1;
        chk("rjrd_waitreq_in_rst", 32'(avs_waitrequest), 32'd1);
        chk("rjrd_ram_wr_in_rst", 32'(ram_wr), 32'd0);
        @(negedge clk);
        ref_a = '0; ref_dreg = '0; ref_err = 1'b0; ref_ready = 1'b0;
        chk("rjrd_state_idle", 32'(dbg_state), 32'd0);
        chk("rjrd_jreq", 32'(dbg_jreq_valid), 32'd0);
        chk("rjrd_waitreq", 32'(avs_waitrequest), 32'd1);
        check_model("rjrd");
        reset = 1'b0; avs_write = 1'b0;

        // ---- randomized traffic ----
        for (int t = 0; t < 60; t++) begin
            case ($urandom_range(0, 5))
                0: avs_op(1'b1, 8'($urandom), $urandom, 4'($urandom_range(0, 15)));
                1: avs_op(1'b0, 8'($urandom), 32'd0, 4'd0);
                2: jtag_cmd(0, jdo_load(8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))));
                3: jtag_cmd(1, jdo_wr($urandom));
                4: jtag_cmd(2, '0);
                default: fork
                    avs_op(1'b0, 8'($urandom), 32'd0, 4'd0);
                    jtag_cmd(2, '0);
                join
            endcase
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        @(negedge clk);
        check_model("final");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
